// File: rtl/ym3438_prescaler_gen_pkg.sv
// Shared constants and helpers for the YM3438 clock-phase prescaler.
// The divide-ratio clamp is kept here so every user rounds the same way.
package ym3438_pkg;

   localparam int unsigned MIN_DIV = 4;

   // Drop bit 0, then clamp into MIN_DIV..max_div (max_div is even).
   function automatic int unsigned prescaler_clamp_div(input int unsigned div,
                                                       input int unsigned max_div);
      int unsigned d;
      d = div & ~32'd1;
      if (d < MIN_DIV)
         d = MIN_DIV;
      else if (d > max_div)
         d = max_div & ~32'd1;
      return d;
   endfunction

endpackage

// File: rtl/ym3438_prescaler_gen_tick_sr.sv
// Tick-enabled shift register with synchronous reset; q is the oldest stage.
// Serves as both the reset_fsm delay line and the decode output register.
module ym3438_tick_sr #(
   parameter int SR_LENGTH = 1,
   parameter int WIDTH     = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [SR_LENGTH-1:0][WIDTH-1:0] stage;

   always_ff @(posedge clk) begin
      if (rst) begin
         stage <= '0;
      end else if (en) begin
         stage[0] <= d;
         for (int i = 1; i < SR_LENGTH; i++)
            stage[i] <= stage[i-1];
      end
   end

   assign q = stage[SR_LENGTH-1];

endmodule

// File: rtl/ym3438_prescaler_gen.sv
// YM3438 phase generator: divides the PHI tick stream by an even ratio,
// emits non-overlapping c1/c2 enables and sequences the delayed reset_fsm.
module ym3438_prescaler_gen
   import ym3438_pkg::*;
#(
   parameter int MAX_DIV = 12,
   parameter int CNT_W   = $clog2(MAX_DIV),
   parameter int IC_WIN  = 12,
   parameter int RES_DLY = 4,
   parameter int DEF_DIV = 6
) (
   input  logic             MCLK,
   input  logic             IC,
   input  logic             tick,
   input  logic             ic_req,
   input  logic [CNT_W-1:0] div,
   output logic             c1,
   output logic             c2,
   output logic [CNT_W-1:0] phase,
   output logic             cycle_start,
   output logic             reset_fsm
);

   localparam int               IC_W     = $clog2(IC_WIN + 1);
   localparam logic [IC_W-1:0]  IC_WIN_C = IC_W'(IC_WIN);
   localparam logic [CNT_W-1:0] DEF_D    = CNT_W'(prescaler_clamp_div(DEF_DIV, MAX_DIV));

   logic [CNT_W-1:0] phase_q;
   logic [CNT_W-1:0] d_act;
   logic [CNT_W-1:0] div_clamped;
   logic [CNT_W-1:0] half;
   logic [IC_W-1:0]  ic_cnt;
   logic             win;
   logic             wrap;
   logic             c1_n;
   logic             c2_n;
   logic             cs_n;
   logic [2:0]       dec_q;

   assign div_clamped = CNT_W'(prescaler_clamp_div(32'(div), MAX_DIV));
   assign win         = ic_req && (ic_cnt < IC_WIN_C);
   assign wrap        = (phase_q == d_act - CNT_W'(1));
   assign half        = d_act >> 1;

   // Decode uses the ratio active for the phase being left, so a pending
   // div change cannot disturb the tail of the current cycle.
   assign c1_n = (phase_q == '0) || wrap;
   assign c2_n = (phase_q == half - CNT_W'(1)) || (phase_q == half);
   assign cs_n = (phase_q == '0);

   always_ff @(posedge MCLK) begin
      if (IC) begin
         phase_q <= '0;
         d_act   <= DEF_D;
         ic_cnt  <= '0;
      end else if (tick) begin
         // A restart window counts as a wrap: phase pinned to 0, ratio resampled.
         if (win || wrap) begin
            phase_q <= '0;
            d_act   <= div_clamped;
         end else begin
            phase_q <= phase_q + CNT_W'(1);
         end
         if (!ic_req)
            ic_cnt <= '0;
         else if (ic_cnt != IC_WIN_C)
            ic_cnt <= ic_cnt + IC_W'(1);
      end
   end

   ym3438_tick_sr #(.SR_LENGTH(1), .WIDTH(3)) u_dec_reg (
      .clk (MCLK),
      .rst (IC),
      .en  (tick),
      .d   ({c1_n, c2_n, cs_n}),
      .q   (dec_q)
   );

   ym3438_tick_sr #(.SR_LENGTH(RES_DLY), .WIDTH(1)) u_res_dly (
      .clk (MCLK),
      .rst (IC),
      .en  (tick),
      .d   (win),
      .q   (reset_fsm)
   );

   assign {c1, c2, cycle_start} = dec_q;
   assign phase = phase_q;

endmodule

// File: doc/ym3438_prescaler_gen.md
Name: ym3438_prescaler_gen

Overview:
Parametrised clock-phase generator and reset sequencer for the YM3438 core.
- Divides the PHI-rate tick stream by a runtime-selectable even ratio.
- Produces registered, non-overlapping c1/c2 phase enables, plus a phase index and cycle-start strobe.
- Sequences a delayed reset_fsm pulse from the chip initial-clear request.
- Runs on MCLK with a PHI-derived tick enable, so the same block serves both PHI-rate and faster-MCLK builds.

Parameters:
- MAX_DIV, 12: largest supported divide ratio (even, >=4).
- CNT_W, $clog2(MAX_DIV): width of the phase counter and div input.
- IC_WIN, 12: ticks of ic_req during which the divider is held/restarted.
- RES_DLY, 4: ticks from restart-window activity to reset_fsm.
- DEF_DIV, 6: divide ratio loaded on IC.

Ports:
- MCLK, input, 1: master clock.
- IC, input, 1: synchronous active-high block reset.
- tick, input, 1: PHI-rate advance enable; all state below advances only when tick=1.
- ic_req, input, 1: chip initial-clear request, active-high, already synchronised to MCLK.
- div, input, CNT_W: requested divide ratio; bit0 ignored; legal 4..MAX_DIV.
- c1, output, 1: phase-1 enable.
- c2, output, 1: phase-2 enable.
- phase, output, CNT_W: current phase index.
- cycle_start, output, 1: high for the tick in which phase==0.
- reset_fsm, output, 1: delayed restart indication to downstream FSMs.

Behaviour:
- IC=1 on an MCLK edge, regardless of tick:
  - phase=0, active ratio = DEF_DIV, ic window counter = 0, delay line cleared.
  - c1=0, c2=0, cycle_start=0, reset_fsm=0.
- Ticks: all registers hold when tick=0. Every latency below is counted in ticks.
- Active ratio D = {div[CNT_W-1:1],1'b0}, clamped to the range 4..MAX_DIV.
  - D is sampled only at wrap (phase==D_active-1 on a tick) and on IC.
  - A mid-cycle div change never shortens or extends the current cycle.
- Phase counter: phase advances 0..D-1, then wraps to 0.
- Restart window:
  - win = ic_req & (ic_cnt < IC_WIN).
  - ic_cnt increments while ic_req=1, saturating at IC_WIN.
  - ic_cnt clears to 0 on any tick with ic_req=0.
  - While win=1, phase is forced to 0 on each tick (divider frozen at phase 0).
  - Once the window expires the divider free-runs even if ic_req stays high.
- Decode, one tick latency (registered from the phase held before the tick):
  - c1 = (phase==0) | (phase==D-1).
  - c2 = (phase==D/2-1) | (phase==D/2).
  - cycle_start = (phase==0).
  - For D=6: c1 is set in phases 0 and 5, c2 in phases 2 and 3.
  - c1 & c2 is never 1 for any legal D.
- Window interaction: during win, phase stays 0, so c1 and cycle_start stay high and c2 stays low.
- reset_fsm:
  - reset_fsm = win delayed by exactly RES_DLY ticks through a shift register.
  - Width equals the window length: IC_WIN ticks if ic_req is held, shorter if ic_req drops early.
- Re-request: an ic_req deassert/reassert mid-run restarts the window from 0 and re-forces phase 0.
  - A new full reset_fsm pulse follows.
- IC asserted mid-window aborts everything immediately, including any in-flight reset_fsm pulse.
- Simultaneous wrap and div change: the new D applies to the following cycle.
- Simultaneous wrap and win: win wins, and D is resampled.

Decomposition:
- Shared package ym3438_pkg holds:
  - the MIN_DIV=4 constant;
  - a function prescaler_clamp_div(div) returning the clamped even ratio.
- One natural sub-module: ym3438_tick_sr, a tick-enabled shift register with synchronous reset.
  - Parameters: SR_LENGTH and WIDTH.
  - Used for the reset_fsm delay line and for the output registers.

Test Plan:
- IC high for 3 MCLK, then tick every MCLK with div=6: the c1 sequence after the first tick is 1,0,0,0,0,1 repeating and c2 is 0,0,1,1,0,0.
  - cycle_start pulses every 6 ticks.
  - c1&c2 never true.
- tick high only on every 3rd MCLK: outputs change only on tick cycles and the period is 18 MCLK; the IC reset still applies on a non-tick cycle.
- ic_req held high for 30 ticks:
  - phase stays 0 for ticks 0..11, then free-runs.
  - reset_fsm is high for exactly 12 ticks starting 4 ticks after ic_req rose.
- ic_req high 5 ticks, low 2, high again: two reset_fsm pulses of widths 5 and 12 ticks, each delayed by 4.
- div changed from 6 to 12 at phase 2: the current cycle completes at 6; the next cycle has 12 phases with c2 in phases 5,6.
  - div=3 gives D=4; div=15 with MAX_DIV=12 clamps to 12.
- IC asserted at the 2nd tick of reset_fsm high: all outputs are 0 on the next MCLK and no residual reset_fsm pulse follows.
